// File: rtl/rs_button_driver.sv
// Debounced push-button front end for the RS latch stage.
// Turns clean presses into fixed-width, mutually exclusive S/R pulses.
module rs_button_driver #(
  parameter int DB_CYCLES = 16,
  parameter int PULSE_W   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_s,
  input  logic btn_r,
  output logic S,
  output logic R,
  output logic busy,
  output logic conflict
);

  localparam int DW  = $clog2(DB_CYCLES);
  localparam int PWW = $clog2(PULSE_W + 1);

  localparam logic [DW-1:0]  DB_MAX = DW'(DB_CYCLES - 1);
  localparam logic [PWW-1:0] PW_MAX = PWW'(PULSE_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    PULSE_S,
    PULSE_R,
    GAP
  } state_e;

  // channel 0 is set, channel 1 is reset
  logic [1:0] btn;
  logic [1:0] sync1_q;
  logic [1:0] sync2_q;
  logic [1:0] db_q;
  logic [1:0] db_d;
  logic [1:0] press;
  logic [1:0] pend_q;
  logic [1:0] pend_d;
  logic [1:0] take;

  logic [DW-1:0] cnt_q [2];
  logic [DW-1:0] cnt_d [2];

  state_e         state_q;
  state_e         state_d;
  logic [PWW-1:0] pcnt_q;
  logic [PWW-1:0] pcnt_d;
  logic           conflict_d;

  logic s_q;
  logic r_q;
  logic busy_q;
  logic conflict_q;

  assign btn = {btn_r, btn_s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  // Only a debounced rising edge counts as a press.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      db_d[i]  = db_q[i];
      cnt_d[i] = '0;
      press[i] = 1'b0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == DB_MAX) begin
          db_d[i]  = ~db_q[i];
          press[i] = ~db_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q <= '0;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      db_q <= db_d;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // A new press on the edge it is consumed re-arms the flag.
  assign pend_d = (pend_q & ~take) | press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pcnt_d     = pcnt_q;
    take       = '0;
    conflict_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        pcnt_d = '0;
        if (&pend_q) begin
          take       = 2'b11;
          conflict_d = 1'b1;
        end else if (pend_q[0]) begin
          take    = 2'b01;
          state_d = PULSE_S;
        end else if (pend_q[1]) begin
          take    = 2'b10;
          state_d = PULSE_R;
        end
      end
      PULSE_S, PULSE_R: begin
        if (pcnt_q == PW_MAX) begin
          pcnt_d  = '0;
          state_d = GAP;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pcnt_q     <= '0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      busy_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      s_q        <= (state_d == PULSE_S);
      r_q        <= (state_d == PULSE_R);
      busy_q     <= (state_d != IDLE);
      conflict_q <= conflict_d;
    end
  end

  assign S        = s_q;
  assign R        = r_q;
  assign busy     = busy_q;
  assign conflict = conflict_q;

endmodule
